parking_sensor_fsm: RTL and testbench
=====================================

PARKING_SENSOR_FSM -- requirements
Module: parking_sensor_fsm

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per sensor input (legal range 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all flops sample on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port sens_a  input  1  outer photo-sensor; asynchronous; 1 = beam blocked.
REQ-005 SHALL have port sens_b  input  1  inner photo-sensor; asynchronous; 1 = beam blocked.
REQ-006 SHALL have port enter  output  1  one-cycle pulse per completed car entry.
REQ-007 SHALL have port exit  output  1  one-cycle pulse per completed car exit.
REQ-008 SHALL have port err  output  1  one-cycle pulse on an illegal sensor transition.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass each sensor through its own SYNC_STAGES-flop synchronizer; the FSM uses only the synchronized pair ab = {a,b}.
REQ-011 SHALL implement states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A and ERR. Any state/ab pair not listed below is illegal.
REQ-012 IDLE: ab=00 -> stay; 10 -> IN_A; 01 -> OUT_B; 11 -> ERR.
REQ-013 IN_A: 10 -> stay; 11 -> IN_AB; 00 -> IDLE (pedestrian or abort, no pulse); 01 -> ERR.
REQ-014 IN_AB: 11 -> stay; 01 -> IN_B; 10 -> IN_A (car reversing); 00 -> ERR.
REQ-015 IN_B: 01 -> stay; 00 -> IDLE and enter pulse; 11 -> IN_AB; 10 -> ERR.
REQ-016 OUT_B, OUT_BA and OUT_A SHALL mirror REQ-013..015 with a and b swapped. OUT_A with ab=00 -> IDLE and exit pulse.
REQ-017 Every illegal pair (two bits changing in one cycle) SHALL move the FSM to ERR and raise err for exactly one cycle.
REQ-018 ERR SHALL hold until ab=00, then return to IDLE with no enter or exit pulse.
REQ-019 enter, exit and err SHALL be registered. Each is high for exactly one cycle per event, and at most one of them is high in any cycle.
REQ-020 Latency: a raw sensor edge that completes a sequence SHALL produce its pulse on rising edge SYNC_STAGES+1 after the edge is first sampled.
REQ-021 busy SHALL be a registered decode of state != IDLE, updated on the same edge as the state.
REQ-022 Back-to-back events SHALL be supported. A new sequence may begin on the cycle after the return to IDLE, with no dead cycle.
REQ-023 Sensor pulses shorter than one clock MAY be missed. The block SHALL NOT filter bounce beyond the synchronizer.

Reset
REQ-024 On reset_n=0 all synchronizer flops SHALL clear to 0 immediately, state SHALL become IDLE, and enter, exit, err and busy SHALL be 0.
REQ-025 Reset asserted mid-sequence SHALL abandon that sequence with no pulse.
REQ-026 After reset_n rises, the first transition SHALL occur no earlier than the first rising edge at which reset_n is sampled high.
REQ-027 The deassertion of reset_n SHALL be synchronized to clk before reaching the FSM, which removes the recovery/removal hazard.

Verification
REQ-028 Car in: ab 00->10->11->01->00, each held 3 cycles -> enter=1 for exactly one cycle, 3 edges after the final 00 is applied (SYNC_STAGES=2); exit=0 and err=0 throughout.
REQ-029 Car out: ab 00->01->11->10->00 -> exit single pulse; enter=0; busy high from first synchronized 01 until the return to IDLE.
REQ-030 Pedestrian: ab 10->00->01->00 -> no enter, no exit, no err; busy high during each partial excursion.
REQ-031 Reversal and illegal pair:
- ab 10->11->10->11->01->00 -> one enter pulse.
- then ab 00->11 -> err one cycle; ab 10 -> FSM stays in ERR; ab 00 -> IDLE, no enter or exit.
REQ-032 Throughput and reset:
- 16 consecutive car-in sequences with no idle gap -> exactly 16 enter pulses.
- reset_n=0 applied while in IN_AB -> outputs 0 immediately; after release with ab=00, state is IDLE and no pulse occurs.

Source files
------------

// File: rtl/parking_sensor_fsm.sv
// Car entry/exit detector for a pair of photo-sensors (a = outer, b = inner); pulses are registered.
// Latency SYNC_STAGES+1 clocks from a raw sensor edge to its pulse; no backpressure, the FSM steps every cycle.
module parking_sensor_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sens_a,
  input  logic sens_b,
  output logic enter,
  output logic exit,
  output logic err,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_BA = 3'd5,
    OUT_A  = 3'd6,
    ERR    = 3'd7
  } state_t;

  state_t state;

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             ab;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], sens_a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], sens_b};
    end
  end

  assign ab = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // Legal moves change one sensor bit at a time; anything else lands in ERR.
  function automatic state_t next_state(input state_t cur, input logic [1:0] in_ab);
    state_t nxt;
    nxt = ERR;
    case (cur)
      IDLE: begin
        case (in_ab)
          2'b00:   nxt = IDLE;
          2'b10:   nxt = IN_A;
          2'b01:   nxt = OUT_B;
          default: nxt = ERR;
        endcase
      end
      IN_A: begin
        case (in_ab)
          2'b10:   nxt = IN_A;
          2'b11:   nxt = IN_AB;
          2'b00:   nxt = IDLE;
          default: nxt = ERR;
        endcase
      end
      IN_AB: begin
        case (in_ab)
          2'b11:   nxt = IN_AB;
          2'b01:   nxt = IN_B;
          2'b10:   nxt = IN_A;
          default: nxt = ERR;
        endcase
      end
      IN_B: begin
        case (in_ab)
          2'b01:   nxt = IN_B;
          2'b00:   nxt = IDLE;
          2'b11:   nxt = IN_AB;
          default: nxt = ERR;
        endcase
      end
      OUT_B: begin
        case (in_ab)
          2'b01:   nxt = OUT_B;
          2'b11:   nxt = OUT_BA;
          2'b00:   nxt = IDLE;
          default: nxt = ERR;
        endcase
      end
      OUT_BA: begin
        case (in_ab)
          2'b11:   nxt = OUT_BA;
          2'b10:   nxt = OUT_A;
          2'b01:   nxt = OUT_B;
          default: nxt = ERR;
        endcase
      end
      OUT_A: begin
        case (in_ab)
          2'b10:   nxt = OUT_A;
          2'b00:   nxt = IDLE;
          2'b11:   nxt = OUT_BA;
          default: nxt = ERR;
        endcase
      end
      default: begin
        nxt = (in_ab == 2'b00) ? IDLE : ERR;
      end
    endcase
    return nxt;
  endfunction

  // Pulses come only from the final step of a sequence, so at most one fires per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state(state, ab);
      busy  <= (next_state(state, ab) != IDLE);
      enter <= (state == IN_B)  && (ab == 2'b00);
      exit  <= (state == OUT_A) && (ab == 2'b00);
      err   <= (state != ERR)   && (next_state(state, ab) == ERR);
    end
  end

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// Directed bench: stimulus queues expected pulses with their cycle, a negedge monitor pops and compares.
module tb_parking_sensor_fsm;

  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int K_NONE  = -1;
  localparam int K_ENTER = 0;
  localparam int K_EXIT  = 1;
  localparam int K_ERR   = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic sens_a  = 1'b0;
  logic sens_b  = 1'b0;
  logic enter;
  logic exit_p;
  logic err;
  logic busy;

  parking_sensor_fsm #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sens_a  (sens_a),
    .sens_b  (sens_b),
    .enter   (enter),
    .exit    (exit_p),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Apply ab, optionally queue the pulse it should complete, then hold for n cycles.
  task automatic drive(input logic [1:0] ab, input int n, input int kind);
    {sens_a, sens_b} = ab;
    if (kind != K_NONE) exp_q.push_back('{kind, cyc + LAT});
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_enter"}, int'(enter), 0);
    check({tag, "_exit"},  int'(exit_p), 0);
    check({tag, "_err"},   int'(err), 0);
    check({tag, "_busy"},  int'(busy), 0);
  endtask

  // Monitor: every pulse must match the head of the queue in kind and cycle.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missed_pulse: kind %0d not seen, expected at cycle %0d (now %0d)", e.kind, e.cyc, cyc);
    end
    if (enter || exit_p || err) begin
      check("pulse_onehot", int'(enter) + int'(exit_p) + int'(err), 1);
      kind = enter ? K_ENTER : (exit_p ? K_EXIT : K_ERR);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Car in, each value held 3 cycles
    drive(2'b00, 3, K_NONE);
    drive(2'b10, 3, K_NONE);
    check("carin_busy", int'(busy), 1);
    drive(2'b11, 3, K_NONE);
    drive(2'b01, 3, K_NONE);
    drive(2'b00, 3, K_ENTER);
    check("carin_idle_busy", int'(busy), 0);

    // Car out
    drive(2'b01, 3, K_NONE);
    check("carout_busy", int'(busy), 1);
    drive(2'b11, 3, K_NONE);
    drive(2'b10, 3, K_NONE);
    drive(2'b00, 3, K_EXIT);
    check("carout_idle_busy", int'(busy), 0);

    // Pedestrian excursions on each side
    drive(2'b10, 3, K_NONE);
    check("ped_a_busy", int'(busy), 1);
    drive(2'b00, 3, K_NONE);
    check("ped_a_idle", int'(busy), 0);
    drive(2'b01, 3, K_NONE);
    check("ped_b_busy", int'(busy), 1);
    drive(2'b00, 3, K_NONE);
    check("ped_b_idle", int'(busy), 0);

    // Reversal inside the gate, then a completed entry
    drive(2'b10, 3, K_NONE);
    drive(2'b11, 3, K_NONE);
    drive(2'b10, 3, K_NONE);
    drive(2'b11, 3, K_NONE);
    drive(2'b01, 3, K_NONE);
    drive(2'b00, 3, K_ENTER);

    // Illegal jump 00 -> 11, ERR holds on 10, clears on 00
    drive(2'b00, 3, K_NONE);
    drive(2'b11, 3, K_ERR);
    check("err_busy", int'(busy), 1);
    drive(2'b10, 3, K_NONE);
    check("err_hold_busy", int'(busy), 1);
    drive(2'b00, 3, K_NONE);
    check("err_exit_busy", int'(busy), 0);

    // 16 back-to-back entries, no gap cycles
    for (int i = 0; i < 16; i++) begin
      drive(2'b10, 1, K_NONE);
      drive(2'b11, 1, K_NONE);
      drive(2'b01, 1, K_NONE);
      drive(2'b00, 1, K_ENTER);
    end
    drive(2'b00, 4, K_NONE);
    check("burst_idle_busy", int'(busy), 0);

    // Reset in the middle of an entry
    drive(2'b10, 3, K_NONE);
    drive(2'b11, 3, K_NONE);
    check("midreset_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    {sens_a, sens_b} = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("postreset_busy", int'(busy), 0);

    // Entry after reset still works
    drive(2'b10, 2, K_NONE);
    drive(2'b11, 2, K_NONE);
    drive(2'b01, 2, K_NONE);
    drive(2'b00, 3, K_ENTER);

    repeat (6) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
